sccb_write_master: RTL and testbench
====================================

Name: sccb_write_master

Overview:
- SCCB (I2C-like) write engine for the OV7670 init path; the responder side of the oCall/oData/iDone register-write handshake issued by the camera configuration sequencer.
- On each request it performs one 3-phase SCCB write: device ID, sub-address, data. It then pulses done back to the sequencer.
- Drives SIOC and SIOD toward the camera pins. SIOD is tri-stated at the top level as siod_oe ? siod_o : 1'bz.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- SCCB_FREQ, 100_000, SIOC frequency in Hz.
- DEV_ID, 8'h42, OV7670 write ID byte (7-bit address plus W bit).
- Derived: QDIV = CLK_FREQ/(SCCB_FREQ*4) clocks per quarter SIOC period; required QDIV >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- iCall  in  1  request level; held high by the requester until iDone is seen
- iData  in  16  {sub-address[15:8], data[7:0]}; sampled when a request is accepted
- oDone  out  1  one-clk pulse at transaction end
- oErr  out  1  NACK flag; valid with oDone
- sioc  out  1  SCCB clock
- siod_o  out  1  SIOD output value
- siod_oe  out  1  SIOD output enable
- siod_i  in  1  SIOD pin readback

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - Outputs: sioc=1, siod_o=1, siod_oe=1, oDone=0, oErr=0.
  - All counters cleared; FSM goes to IDLE.
  - No stop condition is generated on reset.
- Quarter tick: a counter of width $clog2(QDIV) counts 0..QDIV-1. Every SCCB phase ("quarter") lasts exactly QDIV clks. The counter runs only outside IDLE/DONE/RELEASE.
- FSM states: IDLE -> START -> BYTE -> STOP -> DONE -> RELEASE -> IDLE.
- IDLE:
  - sioc=1, siod_o=1, siod_oe=1.
  - When iCall=1 at a clk edge: latch iData into a shift buffer, clear oErr, go to START. This edge is t0.
- START, 4 quarters, as (sioc, siod_o): q0 (1,1); q1 (1,0); q2 (1,0); q3 (0,0).
- BYTE:
  - 3 bytes in order: DEV_ID, iData[15:8], iData[7:0]. MSB first.
  - Each byte is 9 bits; each bit is 4 quarters: q0 sioc=0 with siod_o=bit; q1 and q2 sioc=1; q3 sioc=0.
  - 9th bit (don't-care/ACK): siod_oe=0 for all 4 quarters. siod_oe=1 otherwise.
  - Bit counter 0..8 and byte counter 0..2 wrap back to 0 on entering STOP.
- STOP, 4 quarters, as (sioc, siod_o): q0 (0,0); q1 (1,0); q2 (1,1); q3 (1,1).
- Total time on the bus: 4 + 108 + 4 = 116 quarters.
- DONE:
  - oDone=1 for exactly one clk, in the cycle starting at t0 + 1 + 116*QDIV.
  - Bus lines are idle-high.
- RELEASE:
  - Wait until iCall is sampled 0, then go to IDLE.
  - This keeps the still-high iCall in the cycle after oDone from starting a duplicate write.
  - The earliest next accept is one clk after the first iCall=0 sample.
- iCall or iData changes while busy: ignored; the latched data is used.
- iCall deasserted mid-transaction: the transaction completes normally.
- Back-to-back requests: each yields exactly one bus transaction and exactly one oDone pulse.

Optional Feature:
- Macro: SCCB_ACK_CHECK_EN.
- Defined:
  - siod_i is sampled at the last clk of q2 of each 9th bit.
  - If siod_i=1 (NACK), remaining bytes are skipped and the FSM jumps directly to STOP.
  - oErr=1 is set and held until the next accept; oDone still pulses once.
  - Latency after a NACK shortens accordingly.
- Not defined:
  - siod_i is ignored; the 9th bit is a pure don't-care (still released, siod_oe=0).
  - oErr is constant 0.
  - Latency is always 116*QDIV+1.

Test Plan:
- Common setup for all scenarios: CLK_FREQ=400, SCCB_FREQ=10, so QDIV=10.
- Single write: iCall=1 with iData=16'h1280 -> SIOD bit stream 0x42,X,0x12,X,0x80,X between start/stop; oDone pulses exactly once at t0+1161; sioc toggles 27 times high.
- Sequencer emulation (iCall dropped the clk after oDone, re-raised 2 clks later) with 3 writes 16'h1180, 16'h3a04, 16'h1200 -> exactly 3 transactions, 3 oDone pulses, no duplicate write.
- iCall held high continuously for 5000 clks -> exactly one transaction and one oDone; no second start until iCall is seen low.
- Reset asserted at t0+500 -> sioc=1, siod_oe=1, siod_o=1, oDone=0 immediately; after release, no bus activity until a new iCall.
- With SCCB_ACK_CHECK_EN, drive siod_i=1 during the first ACK slot -> STOP follows immediately after byte 1; oDone pulses with oErr=1. With siod_i=0 throughout -> oErr=0 and full 1161-clk latency.
- iData changed to 16'hFFFF mid-transaction -> transmitted sub-address and data still match the value latched at t0.

Source files
------------

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write engine (device ID, sub-address, data) answering the oCall/oData/iDone handshake.
// Define SCCB_ACK_CHECK_EN to sample the ACK slot and abort to STOP on NACK (oErr set).
module sccb_write_master #(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          SCCB_FREQ = 100_000,
    parameter logic [7:0]  DEV_ID    = 8'h42
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iCall,
    input  logic [15:0] iData,
    output logic        oDone,
    output logic        oErr,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe,
    input  logic        siod_i
);

    localparam int QDIV = CLK_FREQ / (SCCB_FREQ * 4);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BYTE,
        S_STOP,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t      state_q;
    logic [QW-1:0] qcnt_q;
    logic [1:0]  quarter_q;
    logic [3:0]  bit_q;
    logic [1:0]  byte_q;
    logic [23:0] sh_q;
    logic        err_q;
    logic        sioc_q, siod_q, oe_q, done_q;
    logic        sioc_d, siod_d, oe_d, done_d;
    logic        qtick;
    logic        nack;

    assign qtick = (qcnt_q == QLAST);

`ifdef SCCB_ACK_CHECK_EN
    assign nack = (state_q == S_BYTE) && (bit_q == 4'd8) && (quarter_q == 2'd2)
                  && qtick && siod_i;
`else
    logic unused_siod;
    assign unused_siod = siod_i;
    assign nack        = 1'b0;
`endif

    // Bus levels for the current quarter; registered below, so the pins lag the FSM by one clk.
    always_comb begin
        sioc_d = 1'b1;
        siod_d = 1'b1;
        oe_d   = 1'b1;
        done_d = (state_q == S_DONE);
        case (state_q)
            S_START: begin
                sioc_d = (quarter_q != 2'd3);
                siod_d = (quarter_q == 2'd0);
            end
            S_BYTE: begin
                sioc_d = (quarter_q == 2'd1) || (quarter_q == 2'd2);
                siod_d = (bit_q == 4'd8) ? 1'b1 : sh_q[23];
                oe_d   = (bit_q != 4'd8);
            end
            S_STOP: begin
                sioc_d = (quarter_q != 2'd0);
                siod_d = quarter_q[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            sh_q      <= '0;
            err_q     <= 1'b0;
            sioc_q    <= 1'b1;
            siod_q    <= 1'b1;
            oe_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            sioc_q <= sioc_d;
            siod_q <= siod_d;
            oe_q   <= oe_d;
            done_q <= done_d;
            if (nack) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (iCall) begin
                        sh_q    <= {DEV_ID, iData};
                        err_q   <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START, S_BYTE, S_STOP: begin
                    qcnt_q <= qtick ? '0 : qcnt_q + QW'(1);
                    if (qtick) begin
                        quarter_q <= quarter_q + 2'd1;
                        if (quarter_q == 2'd3) begin
                            case (state_q)
                                S_START: state_q <= S_BYTE;
                                S_STOP:  state_q <= S_DONE;
                                default: begin
                                    if (bit_q == 4'd8) begin
                                        bit_q <= '0;
                                        // err_q was set one quarter earlier when the slave NACKed.
                                        if (byte_q == 2'd2 || err_q) begin
                                            byte_q  <= '0;
                                            state_q <= S_STOP;
                                        end else begin
                                            byte_q <= byte_q + 2'd1;
                                        end
                                    end else begin
                                        bit_q <= bit_q + 4'd1;
                                        sh_q  <= {sh_q[22:0], 1'b0};
                                    end
                                end
                            endcase
                        end
                    end
                end
                S_DONE: state_q <= S_RELEASE;
                S_RELEASE: begin
                    // Requester still holds iCall right after oDone; wait for it to drop.
                    if (!iCall) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sioc    = sioc_q;
    assign siod_o  = siod_q;
    assign siod_oe = oe_q;
    assign oDone   = done_q;
    assign oErr    = err_q;

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master: bus decoder feeds a scoreboard of expected write words.
module tb_sccb_write_master;

    logic        clk;
    logic        rst_n;
    logic        iCall;
    logic [15:0] iData;
    logic        oDone;
    logic        oErr;
    logic        sioc;
    logic        siod_o;
    logic        siod_oe;
    logic        siod_i;

    sccb_write_master #(
        .CLK_FREQ (400),
        .SCCB_FREQ(10),
        .DEV_ID   (8'h42)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iCall  (iCall),
        .iData  (iData),
        .oDone  (oDone),
        .oErr   (oErr),
        .sioc   (sioc),
        .siod_o (siod_o),
        .siod_oe(siod_oe),
        .siod_i (siod_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_err = 1'b0;
    logic in_txn   = 1'b0;

    logic [23:0] exp_q[$];
    logic [35:0] got_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus decoder: start/stop detection, data sampled on each SIOC rising edge.
    initial begin : monitor
        logic       line, prev_sioc, prev_line;
        logic [7:0] nrise;
        logic [27:0] sh;
        prev_sioc = 1'b1;
        prev_line = 1'b1;
        nrise     = '0;
        sh        = '0;
        forever begin
            @(negedge clk);
            line = siod_oe ? siod_o : siod_i;
            if (!rst_n) begin
                in_txn = 1'b0;
            end else begin
                if (prev_sioc && sioc && prev_line && !line) begin
                    in_txn = 1'b1;
                    nrise  = '0;
                    sh     = '0;
                end else if (in_txn && sioc && !prev_sioc) begin
                    nrise = nrise + 8'd1;
                    sh    = {sh[26:0], line};
                end else if (in_txn && sioc && prev_sioc && !prev_line && line) begin
                    got_q.push_back({nrise, sh});
                    in_txn = 1'b0;
                end
                if (oDone) begin
                    done_cnt++;
                    done_cyc = cyc;
                    done_err = oErr;
                end
            end
            prev_sioc = sioc;
            prev_line = line;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic start_req(input logic [15:0] d);
        @(posedge clk);
        #1;
        iCall = 1'b1;
        iData = d;
        t0    = cyc + 1;
        exp_q.push_back({8'h42, d});
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        int i = 0;
        while (done_cnt == start && i < budget) begin
            @(posedge clk);
            i++;
        end
        chk("done_seen", 32'(done_cnt != start), 32'd1);
    endtask

    task automatic check_txn(input string tag, input int full);
        logic [23:0] e;
        logic [35:0] g;
        chk({tag, "_ntxn"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            if (full != 0) begin
                chk({tag, "_sioc_bits"}, 32'(g[35:28]) - 32'd1, 32'd27);
                chk({tag, "_devid"}, 32'(g[27:20]), 32'(e[23:16]));
                chk({tag, "_subaddr"}, 32'(g[18:11]), 32'(e[15:8]));
                chk({tag, "_data"}, 32'(g[9:2]), 32'(e[7:0]));
            end else begin
                chk({tag, "_sioc_bits"}, 32'(g[35:28]) - 32'd1, 32'd9);
                chk({tag, "_devid"}, 32'(g[9:2]), 32'(e[23:16]));
            end
        end
    endtask

    initial begin : stimulus
        logic [15:0] seq_data[3];
        int d0;
        seq_data[0] = 16'h1180;
        seq_data[1] = 16'h3a04;
        seq_data[2] = 16'h1200;
        rst_n  = 1'b0;
        iCall  = 1'b0;
        iData  = 16'h0000;
        siod_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sioc", 32'(sioc), 32'd1);
        chk("rst_siod_o", 32'(siod_o), 32'd1);
        chk("rst_siod_oe", 32'(siod_oe), 32'd1);
        chk("rst_oDone", 32'(oDone), 32'd0);
        chk("rst_oErr", 32'(oErr), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single write
        d0 = done_cnt;
        start_req(16'h1280);
        wait_done(1300);
        #1;
        iCall = 1'b0;
        chk("single_latency", 32'(done_cyc - t0), 32'd1161);
        chk("single_oErr", 32'(done_err), 32'd0);
        check_txn("single", 1);
        repeat (5) @(posedge clk);
        chk("single_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Sequencer emulation: drop iCall the clk after oDone, re-raise 2 clks later
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) begin
            start_req(seq_data[k]);
            wait_done(1300);
            #1;
            iCall = 1'b0;
            chk("seq_latency", 32'(done_cyc - t0), 32'd1161);
            check_txn("seq", 1);
            repeat (2) @(posedge clk);
        end
        repeat (20) @(posedge clk);
        chk("seq_done_pulses", 32'(done_cnt - d0), 32'd3);
        chk("seq_no_dup", 32'(got_q.size()) + 32'(in_txn), 32'd0);

        // iCall held high for 5000 clks
        d0 = done_cnt;
        start_req(16'h1200);
        repeat (5000) @(posedge clk);
        chk("held_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("held_no_restart", 32'(in_txn), 32'd0);
        check_txn("held", 1);
        #1;
        iCall = 1'b0;
        repeat (5) @(posedge clk);
        chk("held_idle_sioc", 32'(sioc), 32'd1);

        // iData changed mid-transaction
        start_req(16'h3a04);
        repeat (100) @(posedge clk);
        #1;
        iData = 16'hFFFF;
        wait_done(1300);
        #1;
        iCall = 1'b0;
        check_txn("latched", 1);
        repeat (3) @(posedge clk);

        // Asynchronous reset mid-transaction
        d0 = done_cnt;
        start_req(16'h5566);
        void'(exp_q.pop_back());
        while (cyc < t0 + 500) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_sioc", 32'(sioc), 32'd1);
        chk("midrst_siod_oe", 32'(siod_oe), 32'd1);
        chk("midrst_siod_o", 32'(siod_o), 32'd1);
        chk("midrst_oDone", 32'(oDone), 32'd0);
        iCall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (1500) @(posedge clk);
        chk("midrst_no_txn", 32'(got_q.size()) + 32'(in_txn), 32'd0);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_idle_sioc", 32'(sioc), 32'd1);

        // Slave NACK in the first ACK slot
        siod_i = 1'b1;
        start_req(16'h1280);
`ifdef SCCB_ACK_CHECK_EN
        wait_done(1300);
        #1;
        iCall = 1'b0;
        chk("nack_latency", 32'(done_cyc - t0), 32'd441);
        chk("nack_oErr", 32'(done_err), 32'd1);
        check_txn("nack", 0);
`else
        wait_done(1300);
        #1;
        iCall = 1'b0;
        chk("nack_ignored_latency", 32'(done_cyc - t0), 32'd1161);
        chk("nack_ignored_oErr", 32'(done_err), 32'd0);
        check_txn("nack_ignored", 1);
`endif
        siod_i = 1'b0;
        repeat (3) @(posedge clk);

        // Clean ACK after a NACK clears oErr
        start_req(16'h8001);
        wait_done(1300);
        #1;
        iCall = 1'b0;
        chk("ack_latency", 32'(done_cyc - t0), 32'd1161);
        chk("ack_oErr", 32'(done_err), 32'd0);
        check_txn("ack", 1);
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
